// File: rtl/eth_tx_framer.sv
// Ethernet II frame builder: preamble, SFD, MAC header, RAM payload, FCS.
// Streams one byte per clk125 cycle to the RGMII DDR output stage.
module eth_tx_framer #(
  parameter int          PAYLOAD_LEN = 1024,
  parameter int          ADDR_W      = 11,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          IFG         = 12
) (
  input  logic              clk125,
  input  logic              rst_n,
  input  logic              start,
  input  logic              half,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              overrun
);

  localparam int IW = ADDR_W - 1;
  localparam logic [111:0] HDR_C = {DST_MAC, SRC_MAC, ETHERTYPE};

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, HDR, PAY, FCS, GAP
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              half_q, half_d;
  logic              pend_q, pend_d;
  logic              hpend_q, hpend_d;
  logic              ovr_q, ovr_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       crc_q, crc_d;
  logic [31:0]       crc_inv;
  logic [6:0]        hbase;
  logic              last;

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      half_q  <= 1'b0;
      pend_q  <= 1'b0;
      hpend_q <= 1'b0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
      addr_q  <= '0;
      crc_q   <= '1;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      pend_q  <= pend_d;
      hpend_q <= hpend_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
      addr_q  <= addr_d;
      crc_q   <= crc_d;
    end
  end

  always_comb begin
    last = 1'b0;
    unique case (state_q)
      PRE:     last = (cnt_q == 16'd6);
      SFD:     last = 1'b1;
      HDR:     last = (cnt_q == 16'd13);
      PAY:     last = (cnt_q == 16'(PAYLOAD_LEN - 1));
      FCS:     last = (cnt_q == 16'd3);
      GAP:     last = (cnt_q == 16'(IFG - 1));
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + 16'd1;
    half_d  = half_q;
    pend_d  = pend_q;
    hpend_d = hpend_q;
    ovr_d   = ovr_q;
    fcnt_d  = fcnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (start) begin
        state_d = PRE;
        half_d  = half;
      end
    end else begin
      if (start) begin
        if (pend_q) begin
          ovr_d = 1'b1;
        end else begin
          pend_d  = 1'b1;
          hpend_d = half;
        end
      end
      if (last) begin
        unique case (state_q)
          PRE: state_d = SFD;
          SFD: state_d = HDR;
          HDR: state_d = PAY;
          PAY: state_d = FCS;
          FCS: begin
            state_d = GAP;
            fcnt_d  = fcnt_q + 16'd1;
          end
          default: begin
            // a request seen in the final gap cycle chains straight into PRE
            if (pend_q) begin
              state_d = PRE;
              half_d  = hpend_q;
              pend_d  = 1'b0;
            end else if (start) begin
              state_d = PRE;
              half_d  = half;
              pend_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    crc_inv = ~crc_q;
    hbase   = 7'd104 - {cnt_q[3:0], 3'b000};
    tx_en   = 1'b0;
    tx_data = 8'h00;
    busy    = (state_q != IDLE);
    unique case (state_q)
      PRE: begin
        tx_en   = 1'b1;
        tx_data = 8'h55;
      end
      SFD: begin
        tx_en   = 1'b1;
        tx_data = 8'hD5;
      end
      HDR: begin
        tx_en   = 1'b1;
        tx_data = HDR_C[hbase +: 8];
      end
      PAY: begin
        tx_en   = 1'b1;
        tx_data = rd_data;
      end
      FCS: begin
        tx_en   = 1'b1;
        tx_data = crc_inv[{cnt_q[1:0], 3'b000} +: 8];
      end
      default: begin
        tx_en   = 1'b0;
        tx_data = 8'h00;
      end
    endcase
  end

  // read address runs one byte ahead of tx_data to hide RAM latency
  always_comb begin
    addr_d = addr_q;
    crc_d  = crc_q;
    if (state_q == SFD) begin
      crc_d = '1;
    end
    if (state_q == HDR || state_q == PAY) begin
      crc_d = crc_upd(crc_q, tx_data);
    end
    if (state_q == HDR && cnt_q == 16'd12) begin
      addr_d = {half_q, IW'(0)};
    end
    if (state_q == HDR && cnt_q == 16'd13) begin
      addr_d = {half_q, IW'(1)};
    end
    if (state_q == PAY && cnt_q < 16'(PAYLOAD_LEN - 2)) begin
      addr_d = {half_q, IW'(cnt_q + 16'd2)};
    end
  end

  assign rd_addr   = addr_q;
  assign frame_cnt = fcnt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: scenario table plus byte scoreboard.
// Reset mid-frame and a 46-byte payload build are run by hand.
module tb_eth_tx_framer;

  localparam int N   = 1024;
  localparam int FLEN = 8 + 14 + N + 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        half = 1'b0;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        overrun;

  logic        start46 = 1'b0;
  logic [10:0] rd_addr46;
  logic [7:0]  rd_data46 = 8'h00;
  logic        tx_en46;
  logic [7:0]  tx_data46;
  logic        busy46;
  logic [15:0] frame_cnt46;
  logic        overrun46;

  always #4 clk = ~clk;

  eth_tx_framer dut (
    .clk125(clk), .rst_n(rst_n), .start(start), .half(half),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_en(tx_en),
    .tx_data(tx_data), .busy(busy), .frame_cnt(frame_cnt),
    .overrun(overrun)
  );

  eth_tx_framer #(.PAYLOAD_LEN(46)) dut46 (
    .clk125(clk), .rst_n(rst_n), .start(start46), .half(1'b0),
    .rd_addr(rd_addr46), .rd_data(rd_data46), .tx_en(tx_en46),
    .tx_data(tx_data46), .busy(busy46), .frame_cnt(frame_cnt46),
    .overrun(overrun46)
  );

  logic [7:0] mem [2048];

  always @(posedge clk) begin
    rd_data   <= mem[rd_addr];
    rd_data46 <= mem[rd_addr46];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  logic [7:0] exp_q[$];
  bit         exp_half_q[$];

  task automatic push_frame(input bit h);
    logic [111:0] hdr;
    logic [31:0]  c;
    logic [10:0]  a;
    logic [7:0]   b;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5};
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 14; i++) begin
      b = hdr[111-8*i -: 8];
      exp_q.push_back(b);
      c = crc_step(c, b);
    end
    for (int k = 0; k < N; k++) begin
      a = {h, 10'(k)};
      b = mem[a];
      exp_q.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    exp_half_q.push_back(h);
  endtask

  int          bidx = 0;
  int          gap = 0;
  bit          in_fr = 1'b0;
  bit          fall_ok = 1'b0;
  bit          busy_low = 1'b0;
  bit          cur_half = 1'b0;
  logic [31:0] res = '1;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_fr   = 1'b0;
      fall_ok = 1'b0;
    end else if (tx_en) begin
      if (!in_fr) begin
        in_fr = 1'b1;
        bidx  = 0;
        res   = '1;
        if (fall_ok) begin
          check("ifg length", gap, 12);
          check("busy held in gap", {31'd0, busy_low}, 0);
        end
        fall_ok = 1'b0;
        if (exp_half_q.size() == 0) begin
          flag_fail("unexpected frame");
          cur_half = 1'b0;
        end else begin
          cur_half = exp_half_q.pop_front();
        end
      end
      if (exp_q.size() == 0) flag_fail("extra tx byte");
      else check("tx byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      if (bidx >= 8) res = crc_step(res, tx_data);
      if (bidx == 21)
        check("rd_addr last hdr", {21'd0, rd_addr}, {21'd0, cur_half, 10'd0});
      bidx++;
    end else if (in_fr) begin
      in_fr = 1'b0;
      check("frame length", bidx, FLEN);
      check("crc residual", res, 32'hDEBB_20E3);
      fall_ok  = 1'b1;
      gap      = 1;
      busy_low = !busy;
    end else if (fall_ok) begin
      gap++;
      if (!busy) busy_low = 1'b1;
    end
  end

  int len46 = 0;
  int max46 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_en46) len46++;
      if (busy46 && int'(rd_addr46[9:0]) > max46) max46 = int'(rd_addr46[9:0]);
    end
  end

  typedef struct {
    bit ha;
    bit hb;
    int n_extra;
    bit exp_ovr;
    int exp_frames;
  } vec_t;

  task automatic do_start(input bit h);
    @(posedge clk);
    #1;
    start = 1'b1;
    half  = h;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_half_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int maxc);
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < maxc) begin
      @(negedge clk);
      i++;
    end
    if (busy) flag_fail("idle timeout");
  endtask

  task automatic run_vec(input vec_t v);
    apply_reset();
    check("frame_cnt after reset", {16'd0, frame_cnt}, 0);
    check("overrun after reset", {31'd0, overrun}, 0);
    push_frame(v.ha);
    do_start(v.ha);
    if (v.n_extra > 0) begin
      repeat (300) @(posedge clk);
      push_frame(v.hb);
      for (int i = 0; i < v.n_extra; i++) do_start(v.hb);
    end
    wait_idle(5000);
    check("frame_cnt", {16'd0, frame_cnt}, v.exp_frames);
    check("overrun", {31'd0, overrun}, {31'd0, v.exp_ovr});
    check("scoreboard drained", exp_q.size(), 0);
    if (v.exp_ovr) begin
      repeat (50) @(posedge clk);
      #1;
      check("overrun sticky", {31'd0, overrun}, 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) begin
      a = 11'(i);
      mem[i] = a[7:0] ^ (a[10] ? 8'h5A : 8'h00);
    end
    vecs = '{
      '{1'b0, 1'b0, 0, 1'b0, 1},
      '{1'b1, 1'b0, 0, 1'b0, 1},
      '{1'b0, 1'b1, 1, 1'b0, 2},
      '{1'b1, 1'b0, 2, 1'b1, 2}
    };

    repeat (3) @(posedge clk);
    #1;
    check("reset tx_en", {31'd0, tx_en}, 0);
    check("reset tx_data", {24'd0, tx_data}, 0);
    check("reset rd_addr", {21'd0, rd_addr}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset frame_cnt", {16'd0, frame_cnt}, 0);
    check("reset overrun", {31'd0, overrun}, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    apply_reset();
    push_frame(1'b0);
    do_start(1'b0);
    repeat (22 + 500 - 1) @(posedge clk);
    #1;
    check("tx_en mid frame", {31'd0, tx_en}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("tx_en async drop", {31'd0, tx_en}, 0);
    exp_q.delete();
    exp_half_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("frame_cnt after mid reset", {16'd0, frame_cnt}, 0);
    check("busy after mid reset", {31'd0, busy}, 0);
    push_frame(1'b0);
    do_start(1'b0);
    wait_idle(3000);
    check("frame_cnt post reset frame", {16'd0, frame_cnt}, 1);
    check("scoreboard drained post reset", exp_q.size(), 0);

    len46 = 0;
    max46 = 0;
    @(posedge clk);
    #1;
    start46 = 1'b1;
    @(posedge clk);
    #1;
    start46 = 1'b0;
    for (int i = 0; i < 500 && busy46; i++) @(negedge clk);
    if (busy46) flag_fail("p46 idle timeout");
    check("p46 tx_en length", len46, 72);
    check("p46 max rd index", max46, 45);
    check("p46 frame_cnt", {16'd0, frame_cnt46}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
